// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP control sequencer: control bit map,
// opcodes, T-states, bus-driver mask and per-opcode last microstep.
package sap_ctrl_pkg;

    localparam int OP_W = 4;
    localparam int T_W  = 3;
    localparam int CW_W = 16;

    localparam int CTL_HLT = 15;
    localparam int CTL_MI  = 14;
    localparam int CTL_RI  = 13;
    localparam int CTL_RO  = 12;
    localparam int CTL_IO  = 11;
    localparam int CTL_II  = 10;
    localparam int CTL_AI  = 9;
    localparam int CTL_AO  = 8;
    localparam int CTL_EO  = 7;
    localparam int CTL_SU  = 6;
    localparam int CTL_BI  = 5;
    localparam int CTL_OI  = 4;
    localparam int CTL_CE  = 3;
    localparam int CTL_CO  = 2;
    localparam int CTL_J   = 1;
    localparam int CTL_FI  = 0;

    localparam logic [CW_W-1:0] W_NONE = '0;
    localparam logic [CW_W-1:0] W_HLT  = 16'h0001 << CTL_HLT;
    localparam logic [CW_W-1:0] W_MI   = 16'h0001 << CTL_MI;
    localparam logic [CW_W-1:0] W_RI   = 16'h0001 << CTL_RI;
    localparam logic [CW_W-1:0] W_RO   = 16'h0001 << CTL_RO;
    localparam logic [CW_W-1:0] W_IO   = 16'h0001 << CTL_IO;
    localparam logic [CW_W-1:0] W_II   = 16'h0001 << CTL_II;
    localparam logic [CW_W-1:0] W_AI   = 16'h0001 << CTL_AI;
    localparam logic [CW_W-1:0] W_AO   = 16'h0001 << CTL_AO;
    localparam logic [CW_W-1:0] W_EO   = 16'h0001 << CTL_EO;
    localparam logic [CW_W-1:0] W_SU   = 16'h0001 << CTL_SU;
    localparam logic [CW_W-1:0] W_BI   = 16'h0001 << CTL_BI;
    localparam logic [CW_W-1:0] W_OI   = 16'h0001 << CTL_OI;
    localparam logic [CW_W-1:0] W_CE   = 16'h0001 << CTL_CE;
    localparam logic [CW_W-1:0] W_CO   = 16'h0001 << CTL_CO;
    localparam logic [CW_W-1:0] W_J    = 16'h0001 << CTL_J;
    localparam logic [CW_W-1:0] W_FI   = 16'h0001 << CTL_FI;

    localparam logic [CW_W-1:0] BUS_DRV_MASK =
        W_RO | W_IO | W_AO | W_EO | W_CO;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'he;
    localparam logic [OP_W-1:0] OP_HLT = 4'hf;

    localparam logic [T_W-1:0] T0 = 3'd0;
    localparam logic [T_W-1:0] T1 = 3'd1;
    localparam logic [T_W-1:0] T2 = 3'd2;
    localparam logic [T_W-1:0] T3 = 3'd3;
    localparam logic [T_W-1:0] T4 = 3'd4;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } halt_state_t;

    // Last microstep that carries a non-zero control word.
    function automatic logic [T_W-1:0] last_tstate(input logic [OP_W-1:0] op);
        logic [T_W-1:0] t;
        t = T1;
        case (op)
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT: t = T2;
            OP_LDA, OP_STA:                       t = T3;
            OP_ADD, OP_SUB, OP_HLT:               t = T4;
            default:                              t = T1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (opcode, tstate, flags) -> control word,
// plus a flag marking the opcode's last non-zero microstep.
module sap_microcode_rom
    import sap_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    input  logic [T_W-1:0]  tstate,
    input  logic            flag_c,
    input  logic            flag_z,
    output logic [CW_W-1:0] ctrl_word,
    output logic            last_step
);

    // Fetch is shared; execute steps decode per opcode.
    always_comb begin
        ctrl_word = W_NONE;
        last_step = (tstate == last_tstate(opcode));
        case (tstate)
            T0: ctrl_word = W_CO | W_MI;
            T1: ctrl_word = W_RO | W_II | W_CE;
            default: begin
                case (opcode)
                    OP_LDA: begin
                        if (tstate == T2) ctrl_word = W_IO | W_MI;
                        if (tstate == T3) ctrl_word = W_RO | W_AI;
                    end
                    OP_ADD: begin
                        if (tstate == T2) ctrl_word = W_IO | W_MI;
                        if (tstate == T3) ctrl_word = W_RO | W_BI;
                        if (tstate == T4) ctrl_word = W_EO | W_AI | W_FI;
                    end
                    OP_SUB: begin
                        if (tstate == T2) ctrl_word = W_IO | W_MI;
                        if (tstate == T3) ctrl_word = W_RO | W_BI;
                        if (tstate == T4)
                            ctrl_word = W_EO | W_AI | W_SU | W_FI;
                    end
                    OP_STA: begin
                        if (tstate == T2) ctrl_word = W_IO | W_MI;
                        if (tstate == T3) ctrl_word = W_AO | W_RI;
                    end
                    OP_LDI: begin
                        if (tstate == T2) ctrl_word = W_IO | W_AI;
                    end
                    OP_JMP: begin
                        if (tstate == T2) ctrl_word = W_IO | W_J;
                    end
                    OP_JC: begin
                        if (tstate == T2 && flag_c) ctrl_word = W_IO | W_J;
                    end
                    OP_JZ: begin
                        if (tstate == T2 && flag_z) ctrl_word = W_IO | W_J;
                    end
                    OP_OUT: begin
                        if (tstate == T2) ctrl_word = W_AO | W_OI;
                    end
                    OP_HLT: begin
                        if (tstate == T2) ctrl_word = W_HLT;
                    end
                    default: ctrl_word = W_NONE;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP microcode sequencer: T-state counter, halt FSM, reset sync.
// Optional SEQ_EARLY_END_EN: restart at T0 after an opcode's last step.
module sap_control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int NUM_T = 5,
    parameter int OPC_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step,
    input  logic [OPC_W-1:0]         opcode,
    input  logic                     flag_c,
    input  logic                     flag_z,
    output logic [15:0]              ctrl_word,
    output logic [$clog2(NUM_T)-1:0] tstate,
    output logic                     halted
);

    localparam int TC_W = $clog2(NUM_T);
    localparam logic [TC_W-1:0] T_LAST = TC_W'(NUM_T - 1);

    logic [1:0]      rst_pipe;
    logic            rst_sync;
    logic [TC_W-1:0] t_q;
    logic [TC_W-1:0] t_d;
    halt_state_t     state_q;
    halt_state_t     state_d;
    logic [15:0]     rom_word;
    logic            last_step;

    assign rst_sync = rst_pipe[1];

    // Reset asserts immediately, releases two clk edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_pipe <= 2'b11;
        else     rst_pipe <= {rst_pipe[0], 1'b0};
    end

    // Counter and halt state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q     <= '0;
            state_q <= S_RUN;
        end else if (rst_sync) begin
            t_q     <= '0;
            state_q <= S_RUN;
        end else begin
            t_q     <= t_d;
            state_q <= state_d;
        end
    end

    // Next microstep and halt entry.
    always_comb begin
        t_d     = t_q;
        state_d = state_q;
        if (state_q == S_RUN && step) begin
            if (t_q == T2 && opcode == OP_HLT) begin
                state_d = S_HALT;
            end else if (t_q == T_LAST) begin
                t_d = '0;
`ifdef SEQ_EARLY_END_EN
            end else if (last_step) begin
                t_d = '0;
`endif
            end else begin
                t_d = t_q + 1'b1;
            end
        end
    end

`ifndef SEQ_EARLY_END_EN
    logic unused_last_step;
    assign unused_last_step = last_step;
`endif

    sap_microcode_rom u_rom (
        .opcode    (opcode),
        .tstate    (t_q),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl_word (rom_word),
        .last_step (last_step)
    );

    assign halted    = (state_q == S_HALT);
    assign tstate    = t_q;
    assign ctrl_word = halted ? W_HLT : rom_word;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Randomized bench for sap_control_sequencer against a table model
// of the instruction set, plus directed boundary scenarios.
module tb_sap_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl_word;
    logic [2:0]  tstate;
    logic        halted;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] ucode [16][5];
    int          last_t [16];
    int          m_t;
    bit          m_halt;
    int          halt_cnt;

    always #5 clk = ~clk;

    sap_control_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .opcode    (opcode),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl_word (ctrl_word),
        .tstate    (tstate),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word();
        logic [15:0] w;
        if (m_halt) return 16'h8000;
        w = ucode[opcode][m_t];
        if (opcode == 4'h7 && m_t == 2 && !flag_c) w = 16'h0000;
        if (opcode == 4'h8 && m_t == 2 && !flag_z) w = 16'h0000;
        return w;
    endfunction

    task automatic model_step();
        int nxt;
        if (m_halt) return;
        if (m_t == 2 && opcode == 4'hf) begin
            m_halt = 1'b1;
            return;
        end
        nxt = (m_t + 1) % 5;
`ifdef SEQ_EARLY_END_EN
        if (m_t == last_t[opcode]) nxt = 0;
`endif
        m_t = nxt;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_cw"}, ctrl_word, exp_word());
        check({tag, "_t"}, tstate, m_t);
        check({tag, "_halt"}, halted, m_halt);
        check({tag, "_bus"}, $countones(ctrl_word & 16'h1984) <= 1, 1);
    endtask

    task automatic cycle(input bit s, input logic [3:0] op, input bit c,
                         input bit z, input string tag = "rnd",
                         input int exp_cw = -1, input int exp_t = -1);
        @(negedge clk);
        step = s; opcode = op; flag_c = c; flag_z = z;
        #1;
        check_all(tag);
        if (exp_cw >= 0) check({tag, "_dir_cw"}, ctrl_word, exp_cw);
        if (exp_t >= 0) check({tag, "_dir_t"}, tstate, exp_t);
        @(posedge clk);
        if (s) model_step();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        step = 1'b0;
        #1;
        m_t = 0;
        m_halt = 1'b0;
        halt_cnt = 0;
        check_all(tag);
        check({tag, "_dir_cw"}, ctrl_word, 32'h4004);
        release_rst();
    endtask

    initial begin
        for (int o = 0; o < 16; o++) begin
            ucode[o][0] = 16'h4004;
            ucode[o][1] = 16'h1408;
            for (int t = 2; t < 5; t++) ucode[o][t] = 16'h0000;
            last_t[o] = 1;
        end
        ucode[1][2] = 16'h4800; ucode[1][3] = 16'h1200; last_t[1] = 3;
        ucode[2][2] = 16'h4800; ucode[2][3] = 16'h1020;
        ucode[2][4] = 16'h0281; last_t[2] = 4;
        ucode[3][2] = 16'h4800; ucode[3][3] = 16'h1020;
        ucode[3][4] = 16'h02c1; last_t[3] = 4;
        ucode[4][2] = 16'h4800; ucode[4][3] = 16'h2100; last_t[4] = 3;
        ucode[5][2] = 16'h0a00; last_t[5] = 2;
        ucode[6][2] = 16'h0802; last_t[6] = 2;
        ucode[7][2] = 16'h0802; last_t[7] = 2;
        ucode[8][2] = 16'h0802; last_t[8] = 2;
        ucode[14][2] = 16'h0110; last_t[14] = 2;
        ucode[15][2] = 16'h8000; last_t[15] = 4;

        rst = 1'b1; step = 1'b0; opcode = 4'h1;
        flag_c = 1'b0; flag_z = 1'b0;
        m_t = 0; m_halt = 1'b0; halt_cnt = 0;
        #2;
        check_all("por");
        check("por_dir_cw", ctrl_word, 32'h4004);
        release_rst();

`ifndef SEQ_EARLY_END_EN
        cycle(1, 4'h1, 0, 0, "lda0", 16'h4004, 0);
        cycle(1, 4'h1, 0, 0, "lda1", 16'h1408, 1);
        cycle(1, 4'h1, 0, 0, "lda2", 16'h4800, 2);
        cycle(1, 4'h1, 0, 0, "lda3", 16'h1200, 3);
        cycle(1, 4'h1, 0, 0, "lda4", 16'h0000, 4);
        cycle(0, 4'h1, 0, 0, "lda_wrap", 16'h4004, 0);
`endif

        do_reset("rst_sub");
        cycle(1, 4'h3, 0, 0, "sub0");
        cycle(0, 4'h3, 1, 1, "sub_hold");
        cycle(1, 4'h3, 0, 0, "sub1");
        cycle(1, 4'h3, 0, 0, "sub2");
        cycle(1, 4'h3, 1, 0, "sub3");
        cycle(1, 4'h3, 0, 1, "sub4", 16'h02c1, 4);

        for (int k = 0; k < 2; k++) begin
            logic [3:0] jop;
            jop = (k == 0) ? 4'h7 : 4'h8;
            do_reset("rst_j");
            cycle(1, jop, 1, 1, "j0");
            cycle(1, jop, 1, 1, "j1");
            cycle(0, jop, k == 0, k == 1, "j2_taken", 16'h0802, 2);
            cycle(0, jop, k == 1, k == 0, "j2_not", 16'h0000, 2);
            cycle(1, jop, 1, 1, "j2_step");
            cycle(0, jop, 1, 1, "j_after");
        end

        do_reset("rst_hlt");
        cycle(1, 4'hf, 0, 0, "hlt0");
        cycle(1, 4'hf, 0, 0, "hlt1");
        cycle(1, 4'hf, 0, 0, "hlt2", 16'h8000, 2);
        for (int i = 0; i < 10; i++)
            cycle(1, 4'($urandom_range(0, 15)), 1'($urandom),
                  1'($urandom), "halted", 16'h8000, 2);
        do_reset("rst_unhalt");

        do_reset("rst_add");
        cycle(1, 4'h2, 0, 0, "add0");
        cycle(1, 4'h2, 0, 0, "add1");
        cycle(1, 4'h2, 0, 0, "add2");
        cycle(0, 4'h2, 0, 0, "add3", 16'h1020, 3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        m_t = 0;
        m_halt = 1'b0;
        check_all("async");
        check("async_dir_t", tstate, 0);
        check("async_dir_cw", ctrl_word, 32'h4004);
        release_rst();

        cycle(1, 4'h5, 0, 0, "ldi0", 16'h4004, 0);
        cycle(1, 4'h5, 0, 0, "ldi1", 16'h1408, 1);
        cycle(1, 4'h5, 0, 0, "ldi2", 16'h0a00, 2);
`ifdef SEQ_EARLY_END_EN
        cycle(1, 4'h0, 0, 0, "nop0", 16'h4004, 0);
        cycle(1, 4'h0, 0, 0, "nop1", 16'h1408, 1);
        cycle(0, 4'h0, 0, 0, "nop_end", 16'h4004, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = opcode;
            if (m_t == 1 || $urandom_range(0, 7) == 0) begin
                op = 4'($urandom_range(0, 14));
                if ($urandom_range(0, 19) == 0) op = 4'hf;
            end
            cycle($urandom_range(0, 3) != 0, op, 1'($urandom),
                  1'($urandom));
            if (m_halt) halt_cnt++;
            if (halt_cnt > 6) do_reset("rnd_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
